// File: rtl/axi_dma_master.sv
// rtl/axi_dma_master.sv - AXI4 store-and-forward block copy engine
// One read burst fills the chunk buffer, one write burst drains it; repeat until the block is moved.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

module axi_dma_master #(
  parameter int MAX_BURST = 16
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      start,
  input  logic [31:0]               src_addr,
  input  logic [31:0]               dst_addr,
  input  logic [15:0]               word_cnt,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [`AXI_ADDR_BITS-1:0] ARADDR,
  output logic [`AXI_LEN_BITS-1:0]  ARLEN,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [`AXI_DATA_BITS-1:0] RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY,
  output logic [`AXI_ADDR_BITS-1:0] AWADDR,
  output logic [`AXI_LEN_BITS-1:0]  AWLEN,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [`AXI_DATA_BITS-1:0] WDATA,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY
);

  localparam int PW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(MAX_BURST);
  localparam int LW = `AXI_LEN_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP, S_FIN
  } state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 src_q, src_d, dst_q, dst_d;
  logic [15:0]                 rem_q, rem_d;
  logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic                        err_q, err_d, rd_err_q, rd_err_d;
  logic [`AXI_DATA_BITS-1:0]   buf_q [MAX_BURST];
  logic [15:0]                 beats, src_room, dst_room;
  logic [LW-1:0]               len;
  logic                        last_w;

  // Chunk size only depends on src/dst/rem, which hold still from RADDR through WRESP.
  always_comb begin
    src_room = {3'b000, 13'h1000 - {1'b0, src_q[11:0]}} >> 2;
    dst_room = {3'b000, 13'h1000 - {1'b0, dst_q[11:0]}} >> 2;
    beats    = rem_q;
    if (beats > 16'(MAX_BURST)) beats = 16'(MAX_BURST);
    if (beats > src_room)       beats = src_room;
    if (beats > dst_room)       beats = dst_room;
  end

  assign len    = LW'(beats - 16'd1);
  assign last_w = (16'(rptr_q) == beats - 16'd1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      err_q    <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      err_q    <= err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Extra beats beyond the buffer depth are dropped; the RLAST length check flags them.
  always_ff @(posedge CLK) begin
    if (state_q == S_RDATA && RVALID && wptr_q < PW'(MAX_BURST))
      buf_q[wptr_q[IW-1:0]] <= RDATA;
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    err_d    = err_q;
    rd_err_d = rd_err_q;
    case (state_q)
      S_IDLE: if (start) begin
        src_d    = src_addr & 32'hFFFF_FFFC;
        dst_d    = dst_addr & 32'hFFFF_FFFC;
        rem_d    = word_cnt;
        err_d    = 1'b0;
        rd_err_d = 1'b0;
        state_d  = (word_cnt == 16'd0) ? S_FIN : S_RADDR;
      end
      S_RADDR: if (ARREADY) begin
        wptr_d  = '0;
        rptr_d  = '0;
        state_d = S_RDATA;
      end
      S_RDATA: if (RVALID) begin
        if (wptr_q < PW'(MAX_BURST)) wptr_d = wptr_q + 1'b1;
        if (RRESP != 2'b00) begin
          rd_err_d = 1'b1;
          err_d    = 1'b1;
        end
        if (RLAST) begin
          if (16'(wptr_q) + 16'd1 != beats) err_d = 1'b1;
          state_d = (rd_err_q || RRESP != 2'b00) ? S_FIN : S_WADDR;
        end
      end
      S_WADDR: if (AWREADY) state_d = S_WDATA;
      S_WDATA: if (WREADY) begin
        rptr_d = rptr_q + 1'b1;
        if (last_w) state_d = S_WRESP;
      end
      S_WRESP: if (BVALID) begin
        if (BRESP != 2'b00) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          src_d   = src_q + {14'd0, beats, 2'b00};
          dst_d   = dst_q + {14'd0, beats, 2'b00};
          rem_d   = rem_q - beats;
          state_d = (rem_q == beats) ? S_FIN : S_RADDR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done    = (state_q == S_FIN);
  assign err     = err_q;
  assign ARVALID = (state_q == S_RADDR);
  assign ARADDR  = ARVALID ? src_q : '0;
  assign ARLEN   = ARVALID ? len : '0;
  assign RREADY  = (state_q == S_RDATA);
  assign AWVALID = (state_q == S_WADDR);
  assign AWADDR  = AWVALID ? dst_q : '0;
  assign AWLEN   = AWVALID ? len : '0;
  assign WVALID  = (state_q == S_WDATA);
  assign WDATA   = WVALID ? buf_q[rptr_q[IW-1:0]] : '0;
  assign WLAST   = WVALID && last_w;
  assign BREADY  = (state_q == S_WRESP);

endmodule

// File: tb/tb_axi_dma_master.sv
// tb/tb_axi_dma_master.sv - scoreboard bench for axi_dma_master with a simple AXI slave model
module tb_axi_dma_master;
  logic        CLK = 1'b0, RSTn = 1'b0, start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] word_cnt = '0;
  logic        busy, done, err;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [31:0] RDATA = '0;
  logic [3:0]  ARLEN, AWLEN;
  logic        ARVALID, RREADY, AWVALID, WLAST, WVALID, BREADY;
  logic        ARREADY = 1'b0, RLAST = 1'b0, RVALID = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [1:0]  RRESP = 2'b00, BRESP = 2'b00;

  axi_dma_master #(.MAX_BURST(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .err(err),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] addr; logic [3:0] len; } addr_t;
  typedef struct packed { logic [31:0] data; logic last; } beat_t;

  addr_t exp_ar[$], exp_aw[$];
  beat_t exp_w[$];
  logic  exp_done[$];

  int tests = 0, fails = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, bfire_cyc = 0, r_total = 0, ar_wait = 0;
  int stall_left = 0, r_err_beat = 0;
  bit w_toggle = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // Monitor: compare whatever the DUT presents against the front of each expectation queue.
  initial forever begin
    @(negedge CLK);
    if (RSTn) begin
      if (ARVALID) begin
        check("ar_aw_exclusive", 32'(AWVALID), 32'd0);
        if (!ARREADY) ar_wait++;
        if (exp_ar.size() == 0) unexpected("unexpected_ar", ARADDR);
        else begin
          check("araddr", ARADDR, exp_ar[0].addr);
          check("arlen", 32'(ARLEN), 32'(exp_ar[0].len));
          if (ARREADY) void'(exp_ar.pop_front());
        end
      end
      if (AWVALID) begin
        if (exp_aw.size() == 0) unexpected("unexpected_aw", AWADDR);
        else begin
          check("awaddr", AWADDR, exp_aw[0].addr);
          check("awlen", 32'(AWLEN), 32'(exp_aw[0].len));
          if (AWREADY) void'(exp_aw.pop_front());
        end
      end
      if (WVALID) begin
        if (exp_w.size() == 0) unexpected("unexpected_w", WDATA);
        else begin
          check("wdata", WDATA, exp_w[0].data);
          check("wlast", 32'(WLAST), 32'(exp_w[0].last));
          if (WREADY) void'(exp_w.pop_front());
        end
      end
      if (BVALID && BREADY) bfire_cyc = cyc;
      if (done) begin
        check("busy_in_done", 32'(busy), 32'd0);
        if (exp_done.size() == 0) unexpected("unexpected_done", 32'(err));
        else check("done_err", 32'(err), 32'(exp_done.pop_front()));
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Slave: sample handshakes before the edge, update drives just after it.
  initial begin
    logic        r_active, w_active, b_pend, ar_f, r_f, aw_f, w_f, b_f, wlast_s;
    logic [31:0] r_addr, araddr_s;
    logic [3:0]  arlen_s;
    int          r_left;
    r_active = 0; w_active = 0; b_pend = 0; r_addr = '0; r_left = 0;
    forever begin
      @(negedge CLK);
      ar_f = ARVALID && ARREADY; r_f = RVALID && RREADY; aw_f = AWVALID && AWREADY;
      w_f = WVALID && WREADY; b_f = BVALID && BREADY; wlast_s = WLAST;
      araddr_s = ARADDR; arlen_s = ARLEN;
      @(posedge CLK); #1;
      if (!RSTn) begin
        r_active = 0; w_active = 0; b_pend = 0;
        ARREADY = 0; RVALID = 0; RLAST = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
        continue;
      end
      if (ar_f) begin r_active = 1; r_addr = araddr_s; r_left = int'(arlen_s) + 1; stall_left = 0; end
      if (r_f) begin
        r_total++; r_addr += 4; r_left--;
        if (r_left == 0) r_active = 0;
      end
      if (aw_f) w_active = 1;
      if (w_f && wlast_s) begin w_active = 0; b_pend = 1; end
      if (b_f) b_pend = 0;
      ARREADY = ARVALID && !r_active && stall_left == 0;
      if (ARVALID && !r_active && stall_left > 0) stall_left--;
      RVALID = r_active;
      RDATA  = rd_data(r_addr);
      RLAST  = r_active && r_left == 1;
      RRESP  = (r_active && r_total + 1 == r_err_beat) ? 2'b10 : 2'b00;
      AWREADY = AWVALID && !w_active && !b_pend;
      WREADY  = w_active && (!w_toggle || !WREADY);
      BVALID  = b_pend;
      BRESP   = 2'b00;
    end
  end

  task automatic push_chunk(input logic [31:0] s, input logic [31:0] d, input int beats);
    exp_ar.push_back('{addr: s, len: 4'(beats - 1)});
    exp_aw.push_back('{addr: d, len: 4'(beats - 1)});
    for (int i = 0; i < beats; i++)
      exp_w.push_back('{data: rd_data(s + 32'(4 * i)), last: (i == beats - 1)});
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(posedge CLK); #1;
    src_addr = s; dst_addr = d; word_cnt = n; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n_before);
    int k = 0;
    while (done_cnt == n_before && k < 400) begin @(posedge CLK); k++; end
    if (done_cnt == n_before) unexpected({name, "_done_timeout"}, 32'(k));
    repeat (3) @(posedge CLK);
    check({name, "_ar_left"}, 32'(exp_ar.size()), 32'd0);
    check({name, "_aw_left"}, 32'(exp_aw.size()), 32'd0);
    check({name, "_w_left"}, 32'(exp_w.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge CLK); #1;
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("rst_valids", {27'd0, ARVALID, RREADY, AWVALID, WVALID, BREADY}, 32'd0);
    check("rst_addrs", ARADDR | AWADDR | WDATA | {24'd0, ARLEN, AWLEN}, 32'd0);
    check("rst_wlast", 32'(WLAST), 32'd0);
    RSTn = 1'b1;

    push_chunk(32'h0001_0000, 32'h0002_0000, 4); exp_done.push_back(1'b0);
    n = done_cnt; pulse_start(32'h0001_0000, 32'h0002_0000, 16'd4);
    wait_done("t1", n);
    check("t1_done_after_b", 32'(done_cyc), 32'(bfire_cyc + 1));
    check("t1_err", 32'(err), 32'd0);

    push_chunk(32'h0001_0000, 32'h0002_0000, 16);
    push_chunk(32'h0001_0040, 32'h0002_0040, 16);
    push_chunk(32'h0001_0080, 32'h0002_0080, 8); exp_done.push_back(1'b0);
    n = done_cnt; pulse_start(32'h0001_0000, 32'h0002_0000, 16'd40);
    wait_done("t2", n);

    push_chunk(32'h0001_0FF8, 32'h0002_0000, 2);
    push_chunk(32'h0001_1000, 32'h0002_0008, 2); exp_done.push_back(1'b0);
    n = done_cnt; pulse_start(32'h0001_0FFB, 32'h0002_0000, 16'd4);
    wait_done("t3", n);

    r_total = 0; r_err_beat = 3;
    exp_ar.push_back('{addr: 32'h0001_0000, len: 4'd15}); exp_done.push_back(1'b1);
    n = done_cnt; pulse_start(32'h0001_0000, 32'h0002_0000, 16'd40);
    wait_done("t4", n);
    check("t4_r_beats", 32'(r_total), 32'd16);
    check("t4_err_sticky", 32'(err), 32'd1);
    r_err_beat = 0;
    push_chunk(32'h0001_0000, 32'h0002_0000, 4); exp_done.push_back(1'b0);
    n = done_cnt; pulse_start(32'h0001_0000, 32'h0002_0000, 16'd4);
    check("t4_err_cleared", 32'(err), 32'd0);
    wait_done("t4b", n);

    stall_left = 5; ar_wait = 0; w_toggle = 1'b1;
    push_chunk(32'h0003_0000, 32'h0004_0000, 4); exp_done.push_back(1'b0);
    n = done_cnt; pulse_start(32'h0003_0000, 32'h0004_0000, 16'd4);
    wait_done("t5", n);
    check("t5_ar_wait", 32'(ar_wait), 32'd5);

    push_chunk(32'h0005_0000, 32'h0006_0000, 8);
    pulse_start(32'h0005_0000, 32'h0006_0000, 16'd8);
    n = 0;
    while (!WVALID && n < 200) begin @(negedge CLK); n++; end
    check("t6_reached_wdata", 32'(WVALID), 32'd1);
    repeat (2) @(negedge CLK);
    RSTn = 1'b0; #1;
    check("t6_rst_wvalid", 32'(WVALID), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_done.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK); RSTn = 1'b1; w_toggle = 1'b0;

    exp_done.push_back(1'b0);
    n = done_cnt; pulse_start(32'h0001_0000, 32'h0002_0000, 16'd0);
    check("t7_cnt0_done", 32'(done), 32'd1);
    check("t7_cnt0_busy", 32'(busy), 32'd0);
    wait_done("t7", n);

    push_chunk(32'h0007_0000, 32'h0008_0000, 4); exp_done.push_back(1'b0);
    n = done_cnt; pulse_start(32'h0007_0000, 32'h0008_0000, 16'd4);
    repeat (2) @(posedge CLK); #1;
    check("t8_busy", 32'(busy), 32'd1);
    pulse_start(32'h0009_0000, 32'h000A_0000, 16'd2);
    wait_done("t8", n);
    repeat (20) @(posedge CLK);
    check("t8_single_done", 32'(done_cnt), 32'(n + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_dma_master.md
Name: axi_dma_master

Overview:
AXI4 master copy engine that moves a block of 32-bit words from a source address to a destination address. It sits directly upstream of the SRAM_wrapper slave ports, either directly or through the bus, and drives the AR/R/AW/W/B channels it consumes. Operation is store-and-forward per burst: one read burst fills a local chunk buffer, then one write burst drains it. A single start pulse kicks off the copy, and a done pulse plus a sticky error flag report completion.

Parameters:
MAX_BURST, 16, maximum beats per burst and chunk-buffer depth in words; must be ≤ 2^`AXI_LEN_BITS.

Ports:
CLK  input  1  clock
RSTn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a copy; ignored while busy=1
src_addr  input  32  source byte address; bits[1:0] ignored
dst_addr  input  32  destination byte address; bits[1:0] ignored
word_cnt  input  16  number of 32-bit words to copy
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle completion pulse
err  output  1  sticky error flag; cleared on next accepted start
ARADDR  output  `AXI_ADDR_BITS  read burst address
ARLEN  output  `AXI_LEN_BITS  read beats minus 1
ARVALID  output  1  read address valid
ARREADY  input  1  read address ready
RDATA  input  `AXI_DATA_BITS  read data
RRESP  input  2  read response
RLAST  input  1  last read beat
RVALID  input  1  read data valid
RREADY  output  1  read data ready
AWADDR  output  `AXI_ADDR_BITS  write burst address
AWLEN  output  `AXI_LEN_BITS  write beats minus 1
AWVALID  output  1  write address valid
AWREADY  input  1  write address ready
WDATA  output  `AXI_DATA_BITS  write data
WLAST  output  1  last write beat
WVALID  output  1  write data valid
WREADY  input  1  write data ready
BRESP  input  2  write response
BVALID  input  1  write response valid
BREADY  output  1  write response ready
(The integration level ties IDs to 0, SIZE to 3'b010, BURST to INCR (2'b01), and WSTRB to 4'hF.)

Behaviour:
- Reset (async, RSTn=0): FSM→IDLE. All outputs 0: busy, done, err, every VALID/READY, ARADDR, ARLEN, AWADDR, AWLEN, WDATA, WLAST. Takes effect mid-transfer with no drain; the chunk buffer contents are don't-care.
- FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, FIN.
- IDLE: on start, latch src/dst (with bits[1:0] forced to 0) and word_cnt into rem, and clear err. If word_cnt==0, go to FIN; otherwise go to RADDR. ARVALID rises the cycle after start.
- Chunk size is computed on entry to RADDR: beats = min(rem, MAX_BURST, (4096-src[11:0])>>2, (4096-dst[11:0])>>2). No burst crosses a 4 KB boundary on either side. ARLEN = AWLEN = beats-1.
- RADDR: ARVALID=1, with ARADDR=src and ARLEN held stable until ARREADY. The handshake moves to RDATA.
- RDATA: RREADY=1. Each RVALID&RREADY beat writes RDATA to buf[wptr] and increments wptr.
  - RRESP≠0 sets rd_err and err.
  - The handshake on the beat with RLAST=1 ends the burst. If wptr≠beats at that point, set err.
  - Then go to WADDR, or go to FIN if rd_err is set (no write is issued for that chunk).
- WADDR: AWVALID=1, with AWADDR=dst held until AWREADY. The handshake moves to WDATA.
- WDATA: WVALID=1 and WDATA=buf[rptr]. WLAST=1 when rptr==beats-1. Each WVALID&WREADY advances rptr. The last handshake moves to WRESP. WDATA and WLAST are held stable while WREADY=0.
- WRESP: BREADY=1. On BVALID:
  - if BRESP≠0, set err and go to FIN;
  - otherwise src+=beats*4, dst+=beats*4, rem-=beats; then go to FIN if rem==0, else RADDR.
- FIN: done=1 for exactly one cycle, busy=0 in that cycle, then return to IDLE.
- Only one outstanding transaction at a time; AR and AW are never concurrently valid.
- Address arithmetic wraps modulo 2^32.

Test Plan:
- cnt=4, src=0x0001_0000, dst=0x0002_0000, zero-wait slave → one AR (ADDR 0x10000, LEN 3), 4 R beats, AW (ADDR 0x20000, LEN 3), 4 W beats with WLAST on beat 4 and data matching, done pulse the cycle after the BVALID handshake, err=0.
- cnt=40 → three chunks: ARADDR 0x10000/0x10040/0x10080 with ARLEN 15/15/7; AWADDR 0x20000/0x20040/0x20080; all 40 words land at dst in order.
- src=0x0001_0FF8, dst=0x0002_0000, cnt=4 → two chunks of 2 beats: ARADDR 0x10FF8 then 0x11000, AWADDR 0x20000 then 0x20008, LEN=1 each.
- cnt=40, RRESP=2'b10 on beat 3 of the first burst → all 16 R beats accepted, no AW ever asserted, err=1, one done pulse. A following start with good responses clears err.
- ARREADY low for 5 cycles and WREADY toggling 1/0 → ARADDR/ARLEN stable throughout the wait, WDATA order intact, no duplicated or dropped beats. Asserting RSTn=0 mid-WDATA drops WVALID and busy immediately.
- cnt=0 → done pulse the cycle after start, no VALID asserted. A start pulse while busy=1 → ignored, and the current copy completes unchanged.
